// File: rtl/ring_osc_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement scheduler.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    REPORT
  } state_t;

  localparam int unsigned DEF_N_OSC         = 4;
  localparam int unsigned DEF_GATE_W        = 16;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/ring_osc_scheduler_tick_sync.sv
// Two-flop synchronizer and rising-edge detector for one divided oscillator output.
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], tick};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ring_osc_scheduler.sv
// Ring-oscillator measurement scheduler: settle, gated edge count, report; single or scan.
module ring_osc_scheduler
  import ring_osc_pkg::*;
#(
  parameter int unsigned N_OSC         = DEF_N_OSC,
  parameter int unsigned GATE_W        = DEF_GATE_W,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     scan,
  input  logic [$clog2(N_OSC)-1:0] sel,
  input  logic [GATE_W-1:0]        gate_len,
  input  logic [N_OSC-1:0]         osc_tick,
  output logic [N_OSC-1:0]         osc_en,
  output logic                     busy,
  output logic                     result_valid,
  output logic [$clog2(N_OSC)-1:0] result_idx,
  output logic [CNT_W-1:0]         result_count,
  output logic                     overflow
);

  localparam int unsigned IDX_W = $clog2(N_OSC);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               scan_q;
  logic [GATE_W-1:0]  gate_q;
  logic [N_OSC-1:0]   osc_en_d;
  logic [N_OSC-1:0]   rise_vec;
  logic               edge_sel;
  logic               latch_cfg;
  logic               enter_settle;
  logic               finish;

  for (genvar g = 0; g < N_OSC; g++) begin : g_sync
    tick_sync u_tick_sync (
      .clk  (clk),
      .rst  (rst),
      .tick (osc_tick[g]),
      .rise (rise_vec[g])
    );
  end

  // osc_en is one-hot on idx whenever busy, so masking with it selects the active edge.
  assign edge_sel = |(rise_vec & osc_en);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    latch_cfg    = 1'b0;
    enter_settle = 1'b0;
    finish       = 1'b0;
    osc_en_d     = '0;

    case (state_q)
      IDLE: begin
        if (start && (scan || (32'(sel) < N_OSC))) begin
          state_d      = SETTLE;
          idx_d        = scan ? '0 : sel;
          latch_cfg    = 1'b1;
          enter_settle = 1'b1;
        end
      end
      SETTLE: begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == '0) begin
          state_d = GATE;
          tmr_d   = TMR_W'(gate_q) - 1'b1;
        end
      end
      GATE: begin
        tmr_d = tmr_q - 1'b1;
        if (edge_sel) begin
          if (cnt_q == '1) ovf_d = 1'b1;
          else             cnt_d = cnt_q + 1'b1;
        end
        if (tmr_q == '0) begin
          state_d = REPORT;
          finish  = 1'b1;
        end
      end
      REPORT: begin
        if (scan_q && (idx_q != IDX_W'(N_OSC - 1))) begin
          state_d      = SETTLE;
          idx_d        = idx_q + 1'b1;
          enter_settle = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_settle) begin
      tmr_d = TMR_W'(SETTLE_CYCLES - 1);
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    // Abort overrides every transition and suppresses the pending result.
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      idx_d        = idx_q;
      finish       = 1'b0;
    end

    for (int unsigned i = 0; i < N_OSC; i++) begin
      osc_en_d[i] = (state_d != IDLE) && (idx_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tmr_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      scan_q       <= 1'b0;
      gate_q       <= GATE_W'(1);
      osc_en       <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      result_count <= '0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      osc_en       <= osc_en_d;
      result_valid <= finish;
      if (latch_cfg) begin
        scan_q <= scan;
        gate_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
      end
      if (finish) begin
        result_idx   <= idx_q;
        result_count <= cnt_d;
        overflow     <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_scheduler.sv
// Directed/randomized self-checking bench for ring_osc_scheduler against a sampled-history count model.
module tb_ring_osc_scheduler;

  localparam int S  = 16;
  localparam int N  = 4;
  localparam int N2 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, scan = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] gate_len = '0;
  logic [3:0]  osc_tick = '0;
  logic [3:0]  osc_en;
  logic        busy, result_valid, overflow;
  logic [1:0]  result_idx;
  logic [15:0] result_count;

  logic        start2 = 1'b0, abort2 = 1'b0, scan2 = 1'b0;
  logic [1:0]  sel2 = '0;
  logic [15:0] gate_len2 = '0;
  logic [2:0]  osc_en2;
  logic        busy2, result_valid2, overflow2;
  logic [1:0]  result_idx2;
  logic [3:0]  result_count2;

  int total = 0;
  int bad   = 0;
  int hp[N];
  int ph[N];
  logic [3:0] hist[$];
  int edge_n = -1;

  ring_osc_scheduler #(.N_OSC(N), .GATE_W(16), .CNT_W(16), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .scan(scan), .sel(sel),
    .gate_len(gate_len), .osc_tick(osc_tick), .osc_en(osc_en), .busy(busy),
    .result_valid(result_valid), .result_idx(result_idx), .result_count(result_count),
    .overflow(overflow)
  );

  ring_osc_scheduler #(.N_OSC(N2), .GATE_W(16), .CNT_W(4), .SETTLE_CYCLES(S)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .scan(scan2), .sel(sel2),
    .gate_len(gate_len2), .osc_tick(osc_tick[2:0]), .osc_en(osc_en2), .busy(busy2),
    .result_valid(result_valid2), .result_idx(result_idx2), .result_count(result_count2),
    .overflow(overflow2)
  );

  initial forever #5 clk = ~clk;

  // Square-wave oscillators, changing well away from the sampling edge.
  initial forever begin
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      if (hp[k] == 0) osc_tick[k] = 1'b0;
      else begin
        ph[k]++;
        if (ph[k] >= hp[k]) begin
          ph[k] = 0;
          osc_tick[k] = ~osc_tick[k];
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    hist.push_back(osc_tick);
    edge_n = hist.size() - 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising edges seen by the sync path: tick sampled high at edge e-2, low at e-3.
  function automatic int raw_count(int k, int e0, int g);
    int raw = 0;
    logic [3:0] a, b;
    for (int e = e0 + S + 1; e <= e0 + S + g; e++) begin
      a = hist[e-2];
      b = hist[e-3];
      if (a[k] && !b[k]) raw++;
    end
    return raw;
  endfunction

  task automatic tick_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_osc_en"}, osc_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_idx"}, result_idx, 0);
    chk({tag, "_count"}, result_count, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic run_single(input int sel_v, input int gate_v, input string tag);
    int e0, g, raw;
    bit found;
    g = (gate_v == 0) ? 1 : gate_v;
    scan = 1'b0; sel = 2'(sel_v); gate_len = 16'(gate_v); start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n; start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_en_on"}, osc_en, 4'b1 << sel_v);
    wait_valid(S + g + 10, found);
    if (!found) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    raw = raw_count(sel_v, e0, g);
    chk({tag, "_latency"}, edge_n - e0, S + g);
    chk({tag, "_idx"}, result_idx, sel_v);
    chk({tag, "_count"}, result_count, raw);
    chk({tag, "_ovf"}, overflow, 0);
    tick_cycles(1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_en_off"}, osc_en, 0);
  endtask

  task automatic run_scan(input int gate_v, input string tag);
    int e0, g, ej;
    bit found;
    g = (gate_v == 0) ? 1 : gate_v;
    scan = 1'b1; sel = 2'($urandom_range(3)); gate_len = 16'(gate_v); start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n; start = 1'b0;
    chk({tag, "_en0"}, osc_en, 4'b0001);
    for (int j = 0; j < N; j++) begin
      wait_valid(S + g + 10, found);
      if (!found) begin
        chk({tag, "_timeout"}, 0, 1);
        return;
      end
      ej = e0 + j * (S + g + 1);
      chk({tag, "_latency"}, edge_n - e0, j * (S + g + 1) + S + g);
      chk({tag, "_idx"}, result_idx, j);
      chk({tag, "_en"}, osc_en, 4'b1 << j);
      chk({tag, "_count"}, result_count, raw_count(j, ej, g));
      chk({tag, "_ovf"}, overflow, 0);
    end
    tick_cycles(1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_en_off"}, osc_en, 0);
  endtask

  initial begin
    int e0, raw, er, keep_cnt;
    bit found, seen;
    for (int k = 0; k < N; k++) begin
      hp[k] = 0;
      ph[k] = 0;
    end
    tick_cycles(3);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    tick_cycles(2);
    check_reset_outputs("rst_idle");

    // Single measurement, sel=2, 5-clock half-period.
    hp[2] = 5;
    tick_cycles(20);
    run_single(2, 100, "single");

    // Full scan with half-periods 2..5.
    for (int k = 0; k < N; k++) hp[k] = k + 2;
    tick_cycles(12);
    run_scan(120, "scan");

    // gate_len = 0 behaves as 1.
    run_single(1, 0, "gate0");

    // start while busy must not disturb the running measurement.
    scan = 1'b0; sel = 2'd1; gate_len = 16'd50; start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n; start = 1'b0;
    tick_cycles(30);
    sel = 2'd3; gate_len = 16'd7; scan = 1'b1; start = 1'b1;
    tick_cycles(1);
    start = 1'b0;
    chk("busy_start_en", osc_en, 4'b0010);
    wait_valid(S + 60, found);
    if (!found) chk("busy_start_timeout", 0, 1);
    else begin
      chk("busy_start_latency", edge_n - e0, S + 50);
      chk("busy_start_idx", result_idx, 1);
      chk("busy_start_count", result_count, raw_count(1, e0, 50));
      tick_cycles(1);
      chk("busy_start_idle", busy, 0);
    end

    // Abort mid-GATE of the second oscillator in a scan.
    scan = 1'b1; gate_len = 16'd40; start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n; start = 1'b0;
    wait_valid(S + 50, found);
    if (!found) chk("abort_first_timeout", 0, 1);
    keep_cnt = raw_count(0, e0, 40);
    chk("abort_first_count", result_count, keep_cnt);
    er = edge_n;
    tick_cycles(30);
    chk("abort_in_gate_en", osc_en, 4'b0010);
    abort = 1'b1;
    tick_cycles(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_en", osc_en, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_keep_idx", result_idx, 0);
    chk("abort_keep_count", result_count, keep_cnt);
    chk("abort_keep_ovf", overflow, 0);
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick_cycles(1);
      if (result_valid || busy) seen = 1'b1;
    end
    chk("abort_stays_idle", seen, 0);
    chk("abort_gap", edge_n - er > 0, 1);

    // Randomized oscillators, gates and selections.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) hp[k] = 2 + int'($urandom_range(7));
      tick_cycles(3 + int'($urandom_range(9)));
      run_single(int'($urandom_range(3)), 1 + int'($urandom_range(60)), "rand_single");
    end
    run_scan(10 + int'($urandom_range(70)), "rand_scan");

    // Reset asserted mid-SETTLE.
    scan = 1'b0; sel = 2'd3; gate_len = 16'd20; start = 1'b1;
    tick_cycles(1);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    tick_cycles(4);
    run_single(int'($urandom_range(3)), 1 + int'($urandom_range(40)), "after_rst");

    // Narrow instance: out-of-range select is ignored.
    scan2 = 1'b0; sel2 = 2'd3; gate_len2 = 16'd10; start2 = 1'b1;
    tick_cycles(1);
    start2 = 1'b0;
    chk("oor_busy", busy2, 0);
    chk("oor_en", osc_en2, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick_cycles(1);
      if (busy2 || result_valid2) seen = 1'b1;
    end
    chk("oor_stays_idle", seen, 0);

    // Narrow instance: 4-bit counter saturates.
    hp[0] = 2;
    tick_cycles(10);
    sel2 = 2'd0; gate_len2 = 16'd200; start2 = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n; start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < S + 220; i++) begin
      tick_cycles(1);
      if (result_valid2) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("sat_timeout", 0, 1);
    else begin
      raw = raw_count(0, e0, 200);
      chk("sat_latency", edge_n - e0, S + 200);
      chk("sat_count", result_count2, (raw > 15) ? 15 : raw);
      chk("sat_ovf", overflow2, (raw > 15) ? 1 : 0);
      chk("sat_idx", result_idx2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
